// File: rtl/skinny_pkg.sv
// Shared types and cell-level primitives for the SKINNY-128 encrypt engine.
package skinny_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Tweakey cell permutation: new cell i takes old cell TK_PERM[i]
  localparam logic [3:0] TK_PERM [16] = '{4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
                                           4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7};

  function automatic int rounds_for(input int tk_count);
    return 32 + 8 * tk_count;
  endfunction

  // 8-bit S-box built from four NOR/XOR layers with bit permutations in between
  function automatic logic [7:0] sbox8(input logic [7:0] x_in);
    logic [7:0] x;
    x = x_in;
    for (int i = 0; i < 4; i++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       x = {x[7], x[6], x[5], x[4], x[3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  // 6-bit round-constant LFSR step
  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  function automatic logic [7:0] lfsr2(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [7:0] lfsr3(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

endpackage

// File: rtl/skinny128_round.sv
// One combinational SKINNY-128 round. Cell 0 is bits [127:120], cells row-major.
module skinny128_round
  import skinny_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [63:0]  i_rtk,
  input  logic [5:0]   i_rc,
  output logic [127:0] o_state
);

  logic [7:0] w_sub [16];
  logic [7:0] w_shr [16];

  // SubCells, AddConstants and AddRoundTweakey (rows 0-1 only)
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_sub[i] = sbox8(i_state[127-8*i -: 8]);
    end
    w_sub[0] = w_sub[0] ^ {4'h0, i_rc[3:0]};
    w_sub[4] = w_sub[4] ^ {6'h00, i_rc[5:4]};
    w_sub[8] = w_sub[8] ^ 8'h02;
    for (int i = 0; i < 8; i++) begin
      w_sub[i] = w_sub[i] ^ i_rtk[63-8*i -: 8];
    end
  end

  // ShiftRows (row r rotated right by r) followed by MixColumns
  always_comb begin
    o_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_shr[4*r+c] = w_sub[4*r + ((c - r) & 3)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      o_state[127-8*c      -: 8] = w_shr[c] ^ w_shr[8+c] ^ w_shr[12+c];
      o_state[127-8*(4+c)  -: 8] = w_shr[c];
      o_state[127-8*(8+c)  -: 8] = w_shr[4+c] ^ w_shr[8+c];
      o_state[127-8*(12+c) -: 8] = w_shr[c] ^ w_shr[8+c];
    end
  end

endmodule

// File: rtl/skinny128_tk_encrypt.sv
// SKINNY-128-128/256/384 encrypt core: serial load, one round per cycle, serial burst out.
module skinny128_tk_encrypt
  import skinny_pkg::*;
#(
  parameter int TK_COUNT = 3,
  parameter int BUS_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic [BUS_W-1:0] plaintext,
  input  logic [BUS_W-1:0] tweakey,
  output logic [BUS_W-1:0] ciphertext,
  output logic             valid,
  output logic             busy
);

  localparam int PT_BEATS = 128 / BUS_W;
  localparam int TK_BEATS = TK_COUNT * 128 / BUS_W;
  localparam int LD_BEATS = PT_BEATS + TK_BEATS;
  localparam int ROUNDS   = rounds_for(TK_COUNT);
  localparam int TKW      = 128 * TK_COUNT;
  localparam int LD_CW    = $clog2(LD_BEATS + 1);
  localparam int RND_CW   = $clog2(ROUNDS);

  if (TK_COUNT < 1 || TK_COUNT > 3 || BUS_W < 8 || BUS_W > 128 || (128 % BUS_W) != 0) begin : g_param_check
    $error("skinny128_tk_encrypt: illegal TK_COUNT or BUS_W");
  end

  state_t              r_fsm;
  state_t              w_fsm_d;
  logic [LD_CW-1:0]    r_ld_cnt;
  logic [RND_CW-1:0]   r_rnd_cnt;   // round index in RUN, output beat index in OUT
  logic [5:0]          r_rc;
  logic [127:0]        r_blk;
  logic [TKW-1:0]      r_tk;
  logic [TKW-1:0]      w_tk_next;
  logic [63:0]         w_rtk;
  logic [5:0]          w_rc_next;
  logic [127:0]        w_round_out;
  logic                w_rnd_last;
  logic                w_out_last;

  assign w_rc_next  = rc_step(r_rc);
  assign w_rnd_last = (r_rnd_cnt == RND_CW'(ROUNDS - 1));
  assign w_out_last = (r_rnd_cnt == RND_CW'(PT_BEATS - 1));

  skinny128_round u_round (
    .i_state (r_blk),
    .i_rtk   (w_rtk),
    .i_rc    (w_rc_next),
    .o_state (w_round_out)
  );

  // Round tweakey: XOR of rows 0-1 of every TK word
  always_comb begin
    w_rtk = '0;
    for (int j = 0; j < TK_COUNT; j++) begin
      w_rtk = w_rtk ^ r_tk[TKW-1-128*j -: 64];
    end
  end

  // Tweakey schedule: cell permutation on every word, LFSR on rows 0-1 of TK2/TK3
  always_comb begin
    logic [7:0] w_cell;
    w_tk_next = '0;
    w_cell    = '0;
    for (int j = 0; j < TK_COUNT; j++) begin
      for (int i = 0; i < 16; i++) begin
        w_cell = r_tk[TKW-1-128*j-8*int'(TK_PERM[i]) -: 8];
        if (i < 8 && j == 1)      w_cell = lfsr2(w_cell);
        else if (i < 8 && j == 2) w_cell = lfsr3(w_cell);
        w_tk_next[TKW-1-128*j-8*i -: 8] = w_cell;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_d;
  end

  // FSM next state; load takes priority over start in READY
  always_comb begin
    w_fsm_d = r_fsm;
    case (r_fsm)
      S_IDLE:  if (load) w_fsm_d = S_LOAD;
      S_LOAD:  if (load && r_ld_cnt == LD_CW'(LD_BEATS - 1)) w_fsm_d = S_READY;
      S_READY: if (start && !load) w_fsm_d = S_RUN;
      S_RUN:   if (w_rnd_last) w_fsm_d = S_OUT;
      S_OUT:   if (w_out_last) w_fsm_d = S_IDLE;
      default: w_fsm_d = S_IDLE;
    endcase
  end

  // Counters, load shift registers, round datapath and output shifting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ld_cnt  <= '0;
      r_rnd_cnt <= '0;
      r_rc      <= '0;
      r_blk     <= '0;
      r_tk      <= '0;
    end else begin
      case (r_fsm)
        S_IDLE, S_LOAD: begin
          if (load) begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
            if (r_ld_cnt < LD_CW'(PT_BEATS)) r_blk <= (r_blk << BUS_W) | 128'(plaintext);
            else                             r_tk  <= (r_tk << BUS_W) | TKW'(tweakey);
          end
        end
        S_READY: begin
          if (start && !load) begin
            r_rnd_cnt <= '0;
            r_rc      <= '0;
          end
        end
        S_RUN: begin
          r_blk     <= w_round_out;
          r_tk      <= w_tk_next;
          r_rc      <= w_rc_next;
          r_rnd_cnt <= w_rnd_last ? '0 : r_rnd_cnt + 1'b1;
        end
        S_OUT: begin
          r_blk <= r_blk << BUS_W;
          if (w_out_last) begin
            r_rnd_cnt <= '0;
            r_ld_cnt  <= '0;
          end else begin
            r_rnd_cnt <= r_rnd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid      = (r_fsm == S_OUT);
  assign busy       = (r_fsm == S_RUN) || (r_fsm == S_OUT);
  assign ciphertext = valid ? r_blk[127 -: BUS_W] : '0;

endmodule
